edge_detect_mc: RTL and testbench
=================================

Name: edge_detect_mc

Overview:
- Multi-channel, parametrised edge detector for the USB receiver front end and other asynchronous line inputs (D+, D-, misc pins).
- Per channel, in order:
  - SYNC_STAGES-deep synchroniser.
  - Stability (glitch) filter of FILT_CYC cycles.
  - Mode-selectable edge qualification (rise/fall/both/none).
  - One-cycle registered edge pulse and a sticky flag with clear.
- Replaces the single-wire D+ edge detector for multi-line and noisy inputs.

Parameters:
- NUM_CH, 2, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILT_CYC, 1, consecutive differing synchronised samples required before the filtered level changes (>=1; 1 = no filtering beyond one register).
- RST_LEVEL, 1'b1, reset value of every synchroniser flop and filtered level (USB idle J state on D+).
- CNT_W, 8, edge counter width; used only when EDGE_DETECT_CNT_EN is defined.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- d_in  in  NUM_CH  asynchronous line inputs, bit i = channel i.
- edge_mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both. Must be quasi-static.
- flag_clr  in  NUM_CH  synchronous clear of edge_flag[i] (and edge_cnt[i] when enabled).
- d_level  out  NUM_CH  filtered, synchronised level.
- d_edge  out  NUM_CH  one-cycle pulse per qualified edge, registered.
- edge_flag  out  NUM_CH  sticky: set by qualified edge, cleared by flag_clr.

Behaviour:
- Reset values (async on n_rst low): all synchroniser flops = RST_LEVEL, d_level = RST_LEVEL, filter counters = 0, d_edge = 0, edge_flag = 0.
- Synchroniser: plain shift chain; sync_out = last stage.
- Filter, per channel, each clk:
  - If sync_out == d_level: cnt <= 0.
  - Else if cnt == FILT_CYC-1: d_level <= sync_out, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Counter width = $clog2(FILT_CYC+1). Any agreeing sample restarts the count, so pulses shorter than FILT_CYC cycles are suppressed completely.
- Edge qualification: raw rise = d_level 0->1 at that clock, raw fall = 1->0. d_edge[i] <= (rise & mode[0]) | (fall & mode[1]). d_edge is registered in the same clock as the d_level update, so it is high exactly one cycle.
- Latency: if clock edge k is the first to sample a new stable level into stage 1, d_level and d_edge change after edge k+SYNC_STAGES+FILT_CYC-1. Defaults: k+2.
- Input toggling every cycle with FILT_CYC=1: one d_edge pulse per toggle; back-to-back pulses allowed.
- edge_flag: set when d_edge would be set. If set and flag_clr occur in the same cycle, set wins (flag stays 1). flag_clr with no edge: flag <= 0 next cycle.
- Mode 00: d_level still tracks the line; d_edge and edge_flag never set.
- After reset release with the line at !RST_LEVEL: a genuine edge is reported after the normal latency; this is intended.
- Reset mid-filter: count and level revert immediately; no partial state survives.
- Channels are fully independent; no cross-channel priority.

Optional Feature:
- Macro: EDGE_DETECT_CNT_EN.
- Defined: adds output port edge_cnt (CNT_W*NUM_CH). Per-channel counter increments on each d_edge pulse and saturates at 2^CNT_W-1 (no wrap). flag_clr clears it to 0; a simultaneous edge makes it 1. Reset value is 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package edge_detect_pkg holds:
  - typedef enum logic [1:0] edge_mode_t: EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - Mode bit-position constants.
- Sub-module edge_detect_chan: one channel (sync, filter, edge, flag, optional counter). edge_detect_mc instantiates NUM_CH copies in a generate loop and slices the buses.

Test Plan:
- Reset, then d_in held at 1, defaults: d_level = 2'b11, d_edge and edge_flag stay 0 for 20 cycles.
- Channel 0 drops to 0 before edge k, mode 10: d_edge[0] high exactly in the cycle after edge k+2, edge_flag[0] = 1; with mode 01 on the same stimulus, no pulse.
- FILT_CYC=4: 3-cycle low glitch gives no d_level change and no pulse; 4-cycle low gives d_level 0 and one pulse at k+SYNC_STAGES+3.
- Mode 11, FILT_CYC=1, d_in toggling every cycle: one d_edge pulse per toggle, pulses contiguous.
- flag_clr asserted in the same cycle as a qualified edge: edge_flag stays 1; flag_clr alone one cycle later clears it.
- EDGE_DETECT_CNT_EN, CNT_W=2: 5 edges give edge_cnt = 3 (saturated); flag_clr gives 0; n_rst asserted mid-filter gives all outputs at reset values on the same cycle.

Source files
------------

// File: rtl/edge_detect_pkg.sv
// Shared types and constants for the multi-channel edge detector.
package edge_detect_pkg;

  // Per-channel edge qualification mode, two bits per channel on edge_mode.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Bit positions inside one channel's two-bit mode field.
  localparam int MODE_RISE_BIT = 0;
  localparam int MODE_FALL_BIT = 1;

endpackage

// File: rtl/edge_detect_chan.sv
// One channel of the edge detector: synchroniser, stability filter,
// edge qualification, registered pulse, sticky flag.
// Optional saturating edge counter when EDGE_DETECT_CNT_EN is defined.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYC    = 1,
  parameter logic RST_LEVEL   = 1'b1
`ifdef EDGE_DETECT_CNT_EN
  ,parameter int  CNT_W       = 8
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_d,
  input  logic [1:0] i_mode,
  input  logic       i_clr,
  output logic       o_level,
  output logic       o_edge,
  output logic       o_flag
`ifdef EDGE_DETECT_CNT_EN
  ,output logic [CNT_W-1:0] o_cnt
`endif
);

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_edge;
  logic                   r_flag;

  logic w_sync_out;
  logic w_differ;
  logic w_update;
  logic w_set;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_differ   = (w_sync_out != r_level);
  // The level changes only when the disagreement has lasted FILT_CYC samples.
  assign w_update   = w_differ && (r_cnt == FILT_LAST);
  // New level 1 means a rise, new level 0 means a fall.
  assign w_set      = w_update &&
                      (( w_sync_out && i_mode[MODE_RISE_BIT]) ||
                       (!w_sync_out && i_mode[MODE_FALL_BIT]));

  // Synchroniser shift chain, stage 0 takes the raw line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_sync <= {SYNC_STAGES{RST_LEVEL}};
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  // Stability filter: any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_level <= RST_LEVEL;
      r_cnt   <= '0;
    end else if (!w_differ) begin
      r_cnt   <= '0;
    end else if (r_cnt == FILT_LAST) begin
      r_level <= w_sync_out;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Edge pulse registered alongside the level update; sticky flag where set beats clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_edge <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      r_edge <= w_set;
      if (w_set)      r_flag <= 1'b1;
      else if (i_clr) r_flag <= 1'b0;
    end
  end

  assign o_level = r_level;
  assign o_edge  = r_edge;
  assign o_flag  = r_flag;

`ifdef EDGE_DETECT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] r_ecnt;

  // Saturating edge counter; a clear coinciding with an edge leaves it at 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ecnt <= '0;
    end else if (i_clr) begin
      r_ecnt <= w_set ? CNT_W'(1) : '0;
    end else if (w_set && (r_ecnt != CNT_MAX)) begin
      r_ecnt <= r_ecnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_ecnt;
`endif

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: NUM_CH independent copies of edge_detect_chan.
// Optional per-channel edge counters on edge_cnt when EDGE_DETECT_CNT_EN is defined.
module edge_detect_mc
  import edge_detect_pkg::*;
#(
  parameter int   NUM_CH      = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYC    = 1,
  parameter logic RST_LEVEL   = 1'b1,
  parameter int   CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_CH-1:0]     d_in,
  input  logic [2*NUM_CH-1:0]   edge_mode,
  input  logic [NUM_CH-1:0]     flag_clr,
  output logic [NUM_CH-1:0]     d_level,
  output logic [NUM_CH-1:0]     d_edge,
  output logic [NUM_CH-1:0]     edge_flag
`ifdef EDGE_DETECT_CNT_EN
  ,output logic [CNT_W*NUM_CH-1:0] edge_cnt
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_detect_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYC    (FILT_CYC),
      .RST_LEVEL   (RST_LEVEL)
`ifdef EDGE_DETECT_CNT_EN
      ,.CNT_W      (CNT_W)
`endif
    ) u_chan (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_d     (d_in[g]),
      .i_mode  (edge_mode[2*g +: 2]),
      .i_clr   (flag_clr[g]),
      .o_level (d_level[g]),
      .o_edge  (d_edge[g]),
      .o_flag  (edge_flag[g])
`ifdef EDGE_DETECT_CNT_EN
      ,.o_cnt  (edge_cnt[g*CNT_W +: CNT_W])
`endif
    );
  end

`ifndef EDGE_DETECT_CNT_EN
  // Without counters CNT_W has no hardware meaning; keep it referenced as a range check.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_edge_detect_mc.sv
// Self-checking bench for edge_detect_mc. Covers the edge counter when
// EDGE_DETECT_CNT_EN is defined.
module tb_edge_detect_mc;
  import edge_detect_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // DUT A: defaults (2 channels, 2 sync stages, no filtering)
  logic [1:0] d_in_a, clr_a, lvl_a, edge_a, flag_a;
  logic [3:0] mode_a;
  // DUT B: one channel, FILT_CYC = 4
  logic       d_in_b, clr_b, lvl_b, edge_b, flag_b;
  logic [1:0] mode_b;
`ifdef EDGE_DETECT_CNT_EN
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;
`endif

  edge_detect_mc #(.NUM_CH(2), .SYNC_STAGES(2), .FILT_CYC(1), .RST_LEVEL(1'b1), .CNT_W(2)) u_dut_a (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_in      (d_in_a),
    .edge_mode (mode_a),
    .flag_clr  (clr_a),
    .d_level   (lvl_a),
    .d_edge    (edge_a),
    .edge_flag (flag_a)
`ifdef EDGE_DETECT_CNT_EN
    ,.edge_cnt (cnt_a)
`endif
  );

  edge_detect_mc #(.NUM_CH(1), .SYNC_STAGES(2), .FILT_CYC(4), .RST_LEVEL(1'b1), .CNT_W(2)) u_dut_b (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_in      (d_in_b),
    .edge_mode (mode_b),
    .flag_clr  (clr_b),
    .d_level   (lvl_b),
    .d_edge    (edge_b),
    .edge_flag (flag_b)
`ifdef EDGE_DETECT_CNT_EN
    ,.edge_cnt (cnt_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // One clock: inputs set before the call are sampled at this posedge; outputs read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] d;
    logic [3:0] m;
    logic [1:0] c;
    logic [1:0] lvl;
    logic [1:0] edg;
    logic [1:0] flg;
  } vec_t;

  vec_t vt[20];
  int   n_edges;

  initial begin
    // Row i: inputs driven before edge i, expected outputs just after edge i.
    // mode {ch1,ch0}: 11_10 = ch1 both, ch0 fall
    vt[0]  = '{2'b10, 4'b1110, 2'b00, 2'b11, 2'b00, 2'b00};
    vt[1]  = '{2'b10, 4'b1110, 2'b00, 2'b11, 2'b00, 2'b00};
    vt[2]  = '{2'b10, 4'b1110, 2'b00, 2'b10, 2'b01, 2'b01}; // ch0 fall at k+2
    vt[3]  = '{2'b10, 4'b1110, 2'b00, 2'b10, 2'b00, 2'b01};
    vt[4]  = '{2'b10, 4'b1110, 2'b01, 2'b10, 2'b00, 2'b00}; // clear alone
    vt[5]  = '{2'b10, 4'b1110, 2'b00, 2'b10, 2'b00, 2'b00};
    vt[6]  = '{2'b00, 4'b1110, 2'b00, 2'b10, 2'b00, 2'b00};
    vt[7]  = '{2'b00, 4'b1110, 2'b00, 2'b10, 2'b00, 2'b00};
    vt[8]  = '{2'b00, 4'b1110, 2'b00, 2'b00, 2'b10, 2'b10}; // ch1 fall, mode both
    vt[9]  = '{2'b01, 4'b1110, 2'b00, 2'b00, 2'b00, 2'b10};
    vt[10] = '{2'b01, 4'b1110, 2'b00, 2'b00, 2'b00, 2'b10};
    vt[11] = '{2'b01, 4'b1110, 2'b00, 2'b01, 2'b00, 2'b10}; // ch0 rise ignored in fall mode
    vt[12] = '{2'b00, 4'b1101, 2'b00, 2'b01, 2'b00, 2'b10};
    vt[13] = '{2'b00, 4'b1101, 2'b00, 2'b01, 2'b00, 2'b10};
    vt[14] = '{2'b00, 4'b1101, 2'b00, 2'b00, 2'b00, 2'b10}; // ch0 fall ignored in rise mode
    vt[15] = '{2'b00, 4'b1101, 2'b00, 2'b00, 2'b00, 2'b10};
    vt[16] = '{2'b10, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b10};
    vt[17] = '{2'b10, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b10};
    vt[18] = '{2'b10, 4'b0001, 2'b00, 2'b10, 2'b00, 2'b10}; // ch1 mode none: level only
    vt[19] = '{2'b10, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b00};

    // ---- reset ----
    n_rst  = 1'b0;
    d_in_a = 2'b11; mode_a = {EDGE_BOTH, EDGE_FALL}; clr_a = 2'b00;
    d_in_b = 1'b1;  mode_b = EDGE_FALL;              clr_b = 1'b0;
    #12;
    check("rst_lvl_a",  32'(lvl_a),  32'h3);
    check("rst_edge_a", 32'(edge_a), 32'h0);
    check("rst_flag_a", 32'(flag_a), 32'h0);
    check("rst_lvl_b",  32'(lvl_b),  32'h1);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // ---- line held at idle level for 20 cycles ----
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_lvl",  32'(lvl_a),  32'h3);
      check("idle_edge", 32'(edge_a), 32'h0);
      check("idle_flag", 32'(flag_a), 32'h0);
    end

    // ---- vector table ----
    for (int i = 0; i < 20; i++) begin
      d_in_a = vt[i].d; mode_a = vt[i].m; clr_a = vt[i].c;
      step();
      check($sformatf("vec%0d_lvl", i),  32'(lvl_a),  32'(vt[i].lvl));
      check($sformatf("vec%0d_edge", i), 32'(edge_a), 32'(vt[i].edg));
      check($sformatf("vec%0d_flag", i), 32'(flag_a), 32'(vt[i].flg));
    end
    clr_a = 2'b00;

    // ---- ch0 toggling every cycle, mode both: contiguous pulses ----
    mode_a = {EDGE_NONE, EDGE_BOTH};
    for (int j = 0; j < 12; j++) begin
      d_in_a = {1'b1, (j % 2 == 0)};
      step();
      check($sformatf("tog%0d_edge", j), 32'(edge_a[0]), (j >= 2) ? 32'h1 : 32'h0);
      check($sformatf("tog%0d_lvl", j),  32'(lvl_a[0]),  (j >= 2 && j % 2 == 0) ? 32'h1 : 32'h0);
    end
    d_in_a = 2'b11;
    repeat (5) step();
    check("tog_settle_lvl",  32'(lvl_a),  32'h3);
    check("tog_settle_edge", 32'(edge_a), 32'h0);

    // ---- clear coinciding with an edge: set wins ----
    mode_a = {EDGE_NONE, EDGE_FALL};
    clr_a  = 2'b01;
    step();
    check("pre_clr_flag", 32'(flag_a[0]), 32'h0);
    clr_a  = 2'b00;
    d_in_a = 2'b10;
    step();
    check("sw_k_edge", 32'(edge_a[0]), 32'h0);
    step();
    check("sw_k1_edge", 32'(edge_a[0]), 32'h0);
    clr_a = 2'b01;
    step();
    check("sw_k2_edge", 32'(edge_a[0]), 32'h1);
    check("sw_k2_flag", 32'(flag_a[0]), 32'h1);
    step();
    check("sw_k3_flag", 32'(flag_a[0]), 32'h0);
    check("sw_k3_edge", 32'(edge_a[0]), 32'h0);
    clr_a = 2'b00;

    // ---- FILT_CYC=4: 3-cycle glitch suppressed ----
    for (int i = 0; i < 10; i++) begin
      d_in_b = (i < 3) ? 1'b0 : 1'b1;
      step();
      check($sformatf("glitch%0d_lvl", i),  32'(lvl_b),  32'h1);
      check($sformatf("glitch%0d_edge", i), 32'(edge_b), 32'h0);
    end
    // ---- FILT_CYC=4: 4+ cycles low passes, pulse at k+SYNC_STAGES+3 ----
    for (int i = 0; i < 10; i++) begin
      d_in_b = 1'b0;
      step();
      check($sformatf("filt%0d_lvl", i),  32'(lvl_b),  (i >= 5) ? 32'h0 : 32'h1);
      check($sformatf("filt%0d_edge", i), 32'(edge_b), (i == 5) ? 32'h1 : 32'h0);
    end
    check("filt_flag", 32'(flag_b), 32'h1);

`ifdef EDGE_DETECT_CNT_EN
    // ---- saturating counter, CNT_W = 2 ----
    clr_b = 1'b1;
    step();
    check("cnt_clr0", 32'(cnt_b), 32'h0);
    clr_b  = 1'b0;
    mode_b = EDGE_BOTH;
    n_edges = 0;
    for (int t = 0; t < 5; t++) begin
      d_in_b = (t % 2 == 0);
      repeat (8) step();
      n_edges++;
      check($sformatf("cnt_after%0d", n_edges), 32'(cnt_b), (n_edges > 3) ? 32'h3 : 32'(n_edges));
    end
    clr_b = 1'b1;
    step();
    check("cnt_clr1", 32'(cnt_b), 32'h0);
    clr_b = 1'b0;
`endif

    // ---- reset asserted mid-filter ----
    d_in_b = 1'b0;
    repeat (8) step();
    d_in_b = 1'b1;
    repeat (3) step();
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_lvl_b",  32'(lvl_b),  32'h1);
    check("mid_rst_edge_b", 32'(edge_b), 32'h0);
    check("mid_rst_flag_b", 32'(flag_b), 32'h0);
    check("mid_rst_lvl_a",  32'(lvl_a),  32'h3);
    check("mid_rst_edge_a", 32'(edge_a), 32'h0);
    check("mid_rst_flag_a", 32'(flag_a), 32'h0);
`ifdef EDGE_DETECT_CNT_EN
    check("mid_rst_cnt_a", 32'(cnt_a), 32'h0);
    check("mid_rst_cnt_b", 32'(cnt_b), 32'h0);
`endif
    d_in_a = 2'b11;
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_lvl_b",  32'(lvl_b),  32'h1);
      check("post_rst_edge_b", 32'(edge_b), 32'h0);
      check("post_rst_lvl_a",  32'(lvl_a),  32'h3);
    end

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
